// File: rtl/regfile_sb.sv
// regfile_sb -- multi-port register file with byte-enabled dual write-back,
// write-to-read bypass and a per-register busy scoreboard.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   we0/wa0/wd0/wbe0        write port 0 (ALU write-back)
//   we1/wa1/wd1/wbe1        write port 1 (load / multi-cycle, wins per byte)
//   re[NR], ra[NR*AW]       per-port read enable / address
//   rd[NR*DW], rbusy[NR]    combinational read data / source-busy flag
//   alloc, alloc_a          mark a destination register busy
//   busy_cnt[AW+1]          registered popcount of the busy vector

// One read port: stored word plus same-cycle bypass, and the hazard flag.
module regfile_sb_rdport #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            i_re,
    input  logic [AW-1:0]   i_ra,
    input  logic [DW-1:0]   i_stored,
    input  logic            i_busy,
    input  logic            i_hit0,
    input  logic [AW-1:0]   i_wa0,
    input  logic [DW-1:0]   i_wd0,
    input  logic [DW/8-1:0] i_wbe0,
    input  logic            i_hit1,
    input  logic [AW-1:0]   i_wa1,
    input  logic [DW-1:0]   i_wd1,
    input  logic [DW/8-1:0] i_wbe1,
    output logic [DW-1:0]   o_rd,
    output logic            o_rbusy
);
    localparam int NB = DW / 8;

    logic w_zero;
    logic w_byp0;
    logic w_byp1;
    logic [DW-1:0] w_merged;

    assign w_zero = (ZERO_REG != 0) && (i_ra == '0);
    assign w_byp0 = i_hit0 && (i_wa0 == i_ra);
    assign w_byp1 = i_hit1 && (i_wa1 == i_ra);

    always_comb begin
        w_merged = i_stored;
        for (int b = 0; b < NB; b++) begin
            if (w_byp1 && i_wbe1[b])
                w_merged[b*8 +: 8] = i_wd1[b*8 +: 8];
            else if (w_byp0 && i_wbe0[b])
                w_merged[b*8 +: 8] = i_wd0[b*8 +: 8];
        end
    end

    assign o_rd    = (i_re && !w_zero) ? w_merged : '0;
    // A write landing this cycle resolves the hazard, even with all-zero wbe.
    assign o_rbusy = i_re && !w_zero && i_busy && !w_byp0 && !w_byp1;
endmodule

module regfile_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 3,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic [DW/8-1:0]  wbe0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    input  logic [DW/8-1:0]  wbe1,
    input  logic [NR-1:0]    re,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    rbusy,
    input  logic             alloc,
    input  logic [AW-1:0]    alloc_a,
    output logic [AW:0]      busy_cnt
);
    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;

    logic [DEPTH-1:0][DW-1:0] r_mem;
    logic [DEPTH-1:0]         r_busy;
    logic [AW:0]              r_busy_cnt;

    logic                     w_hit0;
    logic                     w_hit1;
    logic                     w_alloc_ok;
    logic [DEPTH-1:0]         w_busy_nxt;
    logic [AW:0]              w_cnt_nxt;

    // Gated by rst_n so bypass data also reads zero while reset is held.
    assign w_hit0     = rst_n && we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign w_hit1     = rst_n && we1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign w_alloc_ok = alloc && !((ZERO_REG != 0) && (alloc_a == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_hit1 && (wa1 == AW'(r)) && wbe1[b])
                        r_mem[r][b*8 +: 8] <= wd1[b*8 +: 8];
                    else if (w_hit0 && (wa0 == AW'(r)) && wbe0[b])
                        r_mem[r][b*8 +: 8] <= wd0[b*8 +: 8];
                end
            end
        end
    end

    // Alloc outranks a same-cycle clearing write: the new producer is younger.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < DEPTH; r++) begin
            if (w_alloc_ok && (alloc_a == AW'(r)))
                w_busy_nxt[r] = 1'b1;
            else if ((w_hit0 && (wa0 == AW'(r))) || (w_hit1 && (wa1 == AW'(r))))
                w_busy_nxt[r] = 1'b0;
        end
    end

    // Count is taken from the next-state vector so it tracks r_busy exactly.
    always_comb begin
        w_cnt_nxt = '0;
        for (int r = 0; r < DEPTH; r++)
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign busy_cnt = r_busy_cnt;

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = ra[k*AW +: AW];

        regfile_sb_rdport #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) u_rdport (
            .i_re     (re[k]),
            .i_ra     (w_ra),
            .i_stored (r_mem[w_ra]),
            .i_busy   (r_busy[w_ra]),
            .i_hit0   (w_hit0),
            .i_wa0    (wa0),
            .i_wd0    (wd0),
            .i_wbe0   (wbe0),
            .i_hit1   (w_hit1),
            .i_wa1    (wa1),
            .i_wd1    (wd1),
            .i_wbe1   (wbe1),
            .o_rd     (rd[k*DW +: DW]),
            .o_rbusy  (rbusy[k])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expectations are queued as stimulus is
// driven (from a small reference model plus directed constants) and are
// drained shortly after, once the combinational outputs have settled.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int NB = DW / 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             we0, we1, alloc;
    logic [AW-1:0]    wa0, wa1, alloc_a;
    logic [DW-1:0]    wd0, wd1;
    logic [NB-1:0]    wbe0, wbe1;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rbusy;
    logic [AW:0]      busy_cnt;

    regfile_sb #(.DW(DW), .AW(AW), .NR(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .wbe0(wbe0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .wbe1(wbe1),
        .re(re), .ra(ra), .rd(rd), .rbusy(rbusy),
        .alloc(alloc), .alloc_a(alloc_a), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 rd, 1 rbusy, 2 busy_cnt
        int          port;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    string       g_tag;
    logic [31:0] m_mem [32];
    bit          m_busy[32];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic expq(input int kind, input int port, input logic [31:0] v, input string tag);
        exp_t e;
        e.kind = kind; e.port = port; e.exp = v; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                0:       act = rd[e.port*DW +: DW];
                1:       act = 32'(rbusy[e.port]);
                default: act = 32'(busy_cnt);
            endcase
            chk(e.tag, act, e.exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit hit(input int p, input int r);
        if (p == 0) return we0 && (int'(wa0) == r) && (r != 0);
        return we1 && (int'(wa1) == r) && (r != 0);
    endfunction

    function automatic logic [31:0] bypass(input int r);
        logic [31:0] v = m_mem[r];
        for (int b = 0; b < NB; b++) begin
            if (hit(1, r) && wbe1[b])      v[b*8 +: 8] = wd1[b*8 +: 8];
            else if (hit(0, r) && wbe0[b]) v[b*8 +: 8] = wd0[b*8 +: 8];
        end
        return v;
    endfunction

    function automatic logic [31:0] mrd(input int k);
        int a = int'(ra[k*AW +: AW]);
        if (!re[k] || a == 0) return 32'h0;
        return bypass(a);
    endfunction

    function automatic logic [31:0] mrbusy(input int k);
        int a = int'(ra[k*AW +: AW]);
        return 32'(re[k] && a != 0 && m_busy[a] && !hit(0, a) && !hit(1, a));
    endfunction

    function automatic logic [31:0] mcnt();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
        return 32'(c);
    endfunction

    task automatic model_step();
        for (int r = 1; r < 32; r++) begin
            logic [31:0] nv = bypass(r);
            if (alloc && int'(alloc_a) == r)  m_busy[r] = 1'b1;
            else if (hit(0, r) || hit(1, r))  m_busy[r] = 1'b0;
            m_mem[r] = nv;
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic idle();
        we0 = 0; wa0 = '0; wd0 = '0; wbe0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0; wbe1 = '0;
        re = '0; ra = '0; alloc = 0; alloc_a = '0;
    endtask

    // Queue model expectations for this cycle, check, then advance the model
    // to match the coming rising edge.
    task automatic cyc();
        for (int k = 0; k < NR; k++) begin
            expq(0, k, mrd(k),    $sformatf("%s.rd%0d", g_tag, k));
            expq(1, k, mrbusy(k), $sformatf("%s.rbusy%0d", g_tag, k));
        end
        expq(2, 0, mcnt(), $sformatf("%s.cnt", g_tag));
        #1;
        drain();
        model_step();
    endtask

    initial begin
        model_reset();
        idle();
        rst_n = 1'b0;
        re = '1;
        ra = {5'd3, 5'd7, 5'd1};
        #2;
        g_tag = "reset";
        for (int k = 0; k < NR; k++) begin
            expq(0, k, 32'h0, $sformatf("reset.rd%0d", k));
            expq(1, k, 32'h0, $sformatf("reset.rbusy%0d", k));
        end
        expq(2, 0, 32'h0, "reset.cnt");
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic write/read, r0 hardwired
        g_tag = "t1w";
        @(negedge clk); idle();
        we0 = 1; wa0 = 5'd3; wd0 = 32'h11223344; wbe0 = 4'hF;
        cyc();
        g_tag = "t1r";
        @(negedge clk); idle();
        re = 3'b011; ra[0 +: AW] = 5'd3; ra[AW +: AW] = 5'd0;
        we0 = 1; wa0 = 5'd0; wd0 = 32'hDEADBEEF; wbe0 = 4'hF;
        expq(0, 0, 32'h11223344, "t1.rd_r3");
        expq(0, 1, 32'h0, "t1.rd_r0_bypass");
        cyc();
        g_tag = "t1z";
        @(negedge clk); idle();
        re = 3'b001; ra[0 +: AW] = 5'd0;
        expq(0, 0, 32'h0, "t1.rd_r0_after_write");
        cyc();

        // 2: dual-port byte merge on one register, with bypass
        g_tag = "t2a";
        @(negedge clk); idle();
        we0 = 1; wa0 = 5'd5; wd0 = 32'hAABBCCDD; wbe0 = 4'hF;
        cyc();
        g_tag = "t2b";
        @(negedge clk); idle();
        we0 = 1; wa0 = 5'd5; wd0 = 32'h11111111; wbe0 = 4'b0011;
        we1 = 1; wa1 = 5'd5; wd1 = 32'h22222222; wbe1 = 4'b0110;
        re = 3'b001; ra[0 +: AW] = 5'd5;
        expq(0, 0, 32'hAA222211, "t2.merge_bypass");
        cyc();
        g_tag = "t2c";
        @(negedge clk); idle();
        re = 3'b001; ra[0 +: AW] = 5'd5;
        expq(0, 0, 32'hAA222211, "t2.merge_stored");
        cyc();

        // 3: alloc then clearing write-back
        g_tag = "t3a";
        @(negedge clk); idle();
        alloc = 1; alloc_a = 5'd7;
        cyc();
        g_tag = "t3b";
        @(negedge clk); idle();
        re = 3'b001; ra[0 +: AW] = 5'd7;
        expq(1, 0, 32'h1, "t3.rbusy_set");
        expq(2, 0, 32'h1, "t3.cnt_one");
        cyc();
        g_tag = "t3c";
        @(negedge clk); idle();
        re = 3'b001; ra[0 +: AW] = 5'd7;
        we1 = 1; wa1 = 5'd7; wd1 = 32'h77; wbe1 = 4'hF;
        expq(1, 0, 32'h0, "t3.rbusy_wb_same_cycle");
        cyc();
        g_tag = "t3d";
        @(negedge clk); idle();
        expq(2, 0, 32'h0, "t3.cnt_cleared");
        cyc();

        // 4: alloc beats same-cycle write, data still stored
        g_tag = "t4a";
        @(negedge clk); idle();
        alloc = 1; alloc_a = 5'd9;
        we0 = 1; wa0 = 5'd9; wd0 = 32'h5A; wbe0 = 4'hF;
        cyc();
        g_tag = "t4b";
        @(negedge clk); idle();
        re = 3'b001; ra[0 +: AW] = 5'd9;
        expq(0, 0, 32'h5A, "t4.rd");
        expq(1, 0, 32'h1, "t4.rbusy");
        expq(2, 0, 32'h1, "t4.cnt");
        cyc();

        // 6: all read ports on a busy register during port-1 write-back
        g_tag = "t6";
        @(negedge clk); idle();
        re = 3'b111; ra = {5'd9, 5'd9, 5'd9};
        we1 = 1; wa1 = 5'd9; wd1 = 32'hCAFEF00D; wbe1 = 4'hF;
        for (int k = 0; k < NR; k++) begin
            expq(0, k, 32'hCAFEF00D, $sformatf("t6.rd%0d", k));
            expq(1, k, 32'h0, $sformatf("t6.rbusy%0d", k));
        end
        cyc();

        // 5: fill the scoreboard, r0 alloc ignored, async reset mid-cycle
        for (int i = 1; i < 32; i++) begin
            g_tag = $sformatf("t5.alloc%0d", i);
            @(negedge clk); idle();
            alloc = 1; alloc_a = AW'(i);
            cyc();
        end
        g_tag = "t5z";
        @(negedge clk); idle();
        alloc = 1; alloc_a = 5'd0;
        expq(2, 0, 32'd31, "t5.cnt_full");
        cyc();
        g_tag = "t5h";
        @(negedge clk); idle();
        re = 3'b111; ra = {5'd31, 5'd9, 5'd5};
        expq(2, 0, 32'd31, "t5.cnt_r0_ignored");
        expq(1, 1, 32'h1, "t5.rbusy_r9");
        cyc();
        @(negedge clk); idle();
        re = 3'b111; ra = {5'd31, 5'd9, 5'd5};
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NR; k++) begin
            expq(0, k, 32'h0, $sformatf("t5.async_rd%0d", k));
            expq(1, k, 32'h0, $sformatf("t5.async_rbusy%0d", k));
        end
        expq(2, 0, 32'h0, "t5.async_cnt");
        drain();
        model_reset();
        #1 rst_n = 1'b1;

        // Random traffic on a small address window for frequent collisions.
        for (int n = 0; n < 300; n++) begin
            g_tag = $sformatf("rnd%0d", n);
            @(negedge clk); idle();
            we0 = 1'($urandom); wa0 = AW'($urandom_range(0, 7));
            wd0 = $urandom; wbe0 = NB'($urandom);
            we1 = 1'($urandom); wa1 = AW'($urandom_range(0, 7));
            wd1 = $urandom; wbe1 = NB'($urandom);
            alloc = 1'($urandom); alloc_a = AW'($urandom_range(0, 7));
            re = NR'($urandom);
            for (int k = 0; k < NR; k++) ra[k*AW +: AW] = AW'($urandom_range(0, 7));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
